serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial adder: adds two WIDTH-bit operands one bit per clock through a single `full_adder` instance plus a registered carry.
- Sits directly around the existing `full_adder` (ports: sum, cout, a, b, cin). It feeds `full_adder` one operand bit per cycle and consumes its sum/cout outputs.
- Area-cheap replacement for a WIDTH-bit ripple adder where throughput is not critical.
- Start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A, captured on accepted start
- b_in  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed (state SHIFT)
- done  output  1  one-cycle pulse: result valid and updated
- sum_out  output  WIDTH  result sum; holds until next completion
- cout  output  1  final carry-out; holds until next completion

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, sum_out=0, cout=0.
  - Internal shift registers, carry register and bit counter all cleared.
- States: IDLE, SHIFT, DONE. Encoding comes from the package. busy=(state==SHIFT), done=(state==DONE); both decoded from registered state, so glitch-free.
- IDLE:
  - start=1 at edge k: load a_sh=a_in, b_sh=b_in, carry=cin, cnt=0, res_sh=0; go to SHIFT.
  - start=0: stay in IDLE; outputs hold.
- SHIFT, one bit per edge:
  - `full_adder` inputs: a=a_sh[0], b=b_sh[0], cin=carry.
  - On each edge: carry<=fa.cout; res_sh<={fa.sum, res_sh[WIDTH-1:1]}; a_sh and b_sh shift right with 0 fill; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (edge k+WIDTH): sum_out<=final res_sh value including this bit; cout<=fa.cout; go to DONE.
- DONE: lasts exactly one cycle, then IDLE at edge k+WIDTH+1.
- Latency:
  - Accepted start at edge k → done high in the cycle after edge k+WIDTH.
  - Next start can be accepted at edge k+WIDTH+2 at the earliest. Initiation interval is WIDTH+2 cycles.
- start in SHIFT or DONE: ignored. It is not queued, and operand inputs are not re-sampled.
- a_in, b_in and cin may change freely after the accepting edge; the result is unaffected.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- sum_out and cout change only at the completion edge (or on reset). Previous values hold through IDLE and SHIFT.
- Counter width: $clog2(WIDTH); it must never wrap within one operation.
- Reset mid-operation: rst_n=0 in SHIFT or DONE aborts the operation and forces the full reset values above. No done pulse for the aborted operation.
- Reset and start at the same edge: reset wins.

Decomposition:
- Package serial_adder_pkg:
  - state localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - STATE_W=2.
- Sub-module: the existing `full_adder`, instantiated exactly once. All sequential logic (FSM, shift registers, carry register, counter) stays in serial_adder.

Test Plan:
- Reset, then WIDTH=8, a=8'h00, b=8'h00, cin=0 → done at edge k+8 (visible in the following cycle); sum_out=8'h00, cout=0; busy high for exactly 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum_out=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 → sum_out=8'h00, cout=1.
- a=8'h3C, b=8'h42, cin=1 → sum_out=8'h7F, cout=0.
  - Hold start=1 continuously: operations are accepted only in IDLE (every 10 cycles).
  - Changing a_in mid-SHIFT does not alter the result.
  - sum_out holds its previous value until the done edge.
- Start a=8'h12, b=8'h34; assert rst_n=0 at the 4th SHIFT cycle → next cycle busy=0, done=0, sum_out=8'h00, cout=0; no done pulse follows.
  - Then a=8'h12, b=8'h34, cin=0 → sum_out=8'h46.
- Randomized self-check: 200 random a/b/cin values at WIDTH=8 and WIDTH=5 against a+b+cin. Check done is exactly one cycle wide and busy and done are never high together.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the one arithmetic cell the serial adder reuses every cycle.
module full_adder (
    output logic sum,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder plus a carry register, LSB first,
// with a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_c;

    full_adder u_fa (
        .sum  (fa_sum),
        .cout (fa_cout),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry)
    );

    assign last_c = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (last_c) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs; busy/done track the next state
    // so they are aligned with, and as clean as, the state register itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_nxt == S_SHIFT);
            done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= a_in;
                        b_sh   <= b_in;
                        carry  <= cin;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                S_SHIFT: begin
                    carry  <= fa_cout;
                    res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // Hold the counter on the final bit so it never wraps.
                    if (last_c) begin
                        sum_out <= {fa_sum, res_sh[WIDTH-1:1]};
                        cout    <= fa_cout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-table plus random bench for serial_adder at WIDTH=8 and WIDTH=5.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start5;
    logic [7:0] a8, b8;
    logic [4:0] a5, b5;
    logic       cin8, cin5;
    logic       busy8, done8, cout8;
    logic       busy5, done5, cout5;
    logic [7:0] sum8;
    logic [4:0] sum5;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
    } vec_t;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .a_in(a5), .b_in(b5), .cin(cin5),
        .busy(busy5), .done(done5), .sum_out(sum5), .cout(cout5)
    );

    function automatic void check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [32:0] result(input int w);
        if (w == 8) return 33'({cout8, sum8});
        return 33'({cout5, sum5});
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : busy5;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : done5;
    endfunction

    // One full operation: start, scramble inputs after acceptance, then watch 20 cycles.
    task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [32:0] exp, input string nm);
        int          busy_cnt;
        int          done_cnt;
        int          done_at;
        logic [32:0] prev;
        @(negedge clk);
        if (w == 8) begin a8 = a; b8 = b; cin8 = ci; start8 = 1'b1; end
        else begin a5 = a[4:0]; b5 = b[4:0]; cin5 = ci; start5 = 1'b1; end
        prev = result(w);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start5 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < 20; i++) begin
            if (busy_of(w)) begin
                busy_cnt++;
                check({nm, " hold"}, result(w), prev);
            end
            if (done_of(w)) begin
                done_cnt++;
                done_at = i;
                check({nm, " result"}, result(w), exp);
            end
            if (busy_of(w) && done_of(w)) check({nm, " busy&done"}, 33'd1, 33'd0);
            @(posedge clk);
            #1;
        end
        check({nm, " busy cycles"}, 33'(busy_cnt), 33'(w));
        check({nm, " done pulses"}, 33'(done_cnt), 33'd1);
        check({nm, " done latency"}, 33'(done_at), 33'(w));
        check({nm, " final result"}, result(w), exp);
    endtask

    vec_t vecs[8];

    initial begin
        int          t_done[$];
        int          found;
        logic [7:0]  ra, rb;
        logic        rc;
        logic [32:0] rexp;

        vecs[0] = '{a: 8'h00, b: 8'h00, ci: 1'b0, s: 8'h00, co: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1};
        vecs[2] = '{a: 8'hA5, b: 8'h5A, ci: 1'b1, s: 8'h00, co: 1'b1};
        vecs[3] = '{a: 8'h3C, b: 8'h42, ci: 1'b1, s: 8'h7F, co: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, co: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'h01, ci: 1'b1, s: 8'h81, co: 1'b0};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1};
        vecs[7] = '{a: 8'h55, b: 8'hAA, ci: 1'b0, s: 8'hFF, co: 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; start5 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a5 = '0; b5 = '0; cin5 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy8", 33'(busy8), 33'd0);
        check("reset done8", 33'(done8), 33'd0);
        check("reset result8", result(8), 33'd0);
        check("reset busy5", 33'(busy5), 33'd0);
        check("reset result5", result(5), 33'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(8, vecs[i].a, vecs[i].b, vecs[i].ci, 33'({vecs[i].co, vecs[i].s}),
                   $sformatf("vec%0d", i));

        // Start held high: accepted only from IDLE, once every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b1; start8 = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                t_done.push_back(i);
                check("held result", result(8), 33'h07F);
            end
        end
        start8 = 1'b0;
        check("held done count", 33'(t_done.size()), 33'd3);
        for (int i = 1; i < t_done.size(); i++)
            check("held interval", 33'(t_done[i] - t_done[i-1]), 33'd10);
        repeat (12) @(posedge clk);

        // Reset in the 4th SHIFT cycle aborts the operation.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre-abort busy", 33'(busy8), 33'd1);
        check("pre-abort result", result(8), 33'h07F);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort busy", 33'(busy8), 33'd0);
        check("abort done", 33'(done8), 33'd0);
        check("abort result", result(8), 33'd0);
        found = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) found++;
        end
        check("abort no done", 33'(found), 33'd0);
        run_op(8, 8'h12, 8'h34, 1'b0, 33'h046, "post-abort");

        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            rexp = 33'(ra) + 33'(rb) + 33'(rc);
            run_op(8, ra, rb, rc, rexp, "rand8");
        end
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 31)); rb = 8'($urandom_range(0, 31)); rc = 1'($urandom);
            rexp = 33'(ra) + 33'(rb) + 33'(rc);
            run_op(5, ra, rb, rc, rexp, "rand5");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
